// File: rtl/cpu_control_unit_if.sv
// Instruction handshake, ALU operand/result bus and display output of the
// control unit, bundled so the sequencer and its environment share one port.
//
// Handshake: an instruction transfers on a rising edge where both
// instr_valid and instr_ready are high. The source holds instr stable until
// that edge. instr_ready is high only while the sequencer is idle. instr_valid
// seen while busy is ignored, and instr changes after the transfer have no effect.
interface cpu_control_unit_if;
    logic               instr_valid;
    logic [17:0]        instr;
    logic               instr_ready;
    logic [2:0]         alu_opcode;
    logic signed [15:0] alu_a;
    logic signed [15:0] alu_b;
    logic signed [15:0] alu_result;
    logic               done;
    logic               disp_valid;
    logic [15:0]        disp_data;

    // Environment side: instruction source plus the ALU instance.
    modport master (
        output instr_valid, instr, alu_result,
        input  instr_ready, alu_opcode, alu_a, alu_b, done, disp_valid, disp_data
    );

    // Sequencer side.
    modport slave (
        input  instr_valid, instr, alu_result,
        output instr_ready, alu_opcode, alu_a, alu_b, done, disp_valid, disp_data
    );
endinterface

// File: rtl/cpu_control_unit.sv
// Multi-cycle sequencer for the 16-bit datapath: accepts one instruction,
// reads operands from a 16x16 register file, drives the external
// combinational ALU, and writes the result back or emits it for display.
// Sequence per instruction: IDLE -> EXEC -> WB -> IDLE.
module cpu_control_unit #(
    parameter int NREGS = 16,
    parameter int IMM_W = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cpu_control_unit_if.slave    bus,
    output logic                 busy,
    input  logic [3:0]           dbg_addr,
    output logic [15:0]          dbg_data,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    localparam logic [2:0] OP_LOAD    = 3'b000;
    localparam logic [2:0] OP_ADD     = 3'b001;
    localparam logic [2:0] OP_ADDI    = 3'b010;
    localparam logic [2:0] OP_SUB     = 3'b011;
    localparam logic [2:0] OP_SUBI    = 3'b100;
    localparam logic [2:0] OP_MUL     = 3'b101;
    localparam logic [2:0] OP_CLEAR   = 3'b110;
    localparam logic [2:0] OP_DISPLAY = 3'b111;

    state_t       state_q;
    state_t       state_d;
    logic [17:0]  instr_q;
    logic [15:0]  res_q;
    logic [15:0]  disp_q;
    logic [15:0]  regs [0:NREGS-1];

    // Fields of the latched instruction.
    logic [2:0]       op;
    logic [3:0]       rd;
    logic [3:0]       rs1;
    logic [3:0]       rs2;
    logic [IMM_W-1:0] imm;
    logic [15:0]      imm_sext;

    assign op       = instr_q[17:15];
    assign rd       = instr_q[14:11];
    assign rs1      = instr_q[10:7];
    assign rs2      = instr_q[6:3];
    assign imm      = instr_q[IMM_W-1:0];
    assign imm_sext = {{(16-IMM_W){imm[IMM_W-1]}}, imm};

    assign dbg_data      = regs[dbg_addr];
    assign dbg_state     = state_q;
    assign bus.disp_data = disp_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic, handshake/status outputs and ALU operand selection.
    always_comb begin
        state_d         = state_q;
        bus.instr_ready = 1'b0;
        busy            = 1'b1;
        bus.done        = 1'b0;
        bus.disp_valid  = 1'b0;
        bus.alu_opcode  = 3'b000;
        bus.alu_a       = '0;
        bus.alu_b       = '0;
        case (state_q)
            S_IDLE: begin
                bus.instr_ready = 1'b1;
                busy            = 1'b0;
                if (bus.instr_valid) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                bus.alu_opcode = op;
                case (op)
                    OP_LOAD: begin
                        bus.alu_a = '0;
                        bus.alu_b = imm_sext;
                    end
                    OP_ADDI, OP_SUBI: begin
                        bus.alu_a = regs[rs1];
                        bus.alu_b = imm_sext;
                    end
                    OP_ADD, OP_SUB, OP_MUL: begin
                        bus.alu_a = regs[rs1];
                        bus.alu_b = regs[rs2];
                    end
                    OP_DISPLAY: begin
                        bus.alu_a = regs[rs1];
                        bus.alu_b = '0;
                    end
                    default: begin
                        bus.alu_a = '0;
                        bus.alu_b = '0;
                    end
                endcase
                state_d = S_WB;
            end
            S_WB: begin
                bus.done       = 1'b1;
                bus.disp_valid = (op == OP_DISPLAY);
                state_d        = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Instruction latch, result capture and display register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= '0;
            res_q   <= '0;
            disp_q  <= '0;
        end else begin
            if (state_q == S_IDLE && bus.instr_valid) begin
                instr_q <= bus.instr;
            end
            if (state_q == S_EXEC) begin
                // CLEAR writes zero whatever the ALU answers for opcode 110.
                res_q <= (op == OP_CLEAR) ? 16'd0 : bus.alu_result;
                // Loaded on entry to WB so the value is on the pins for the
                // whole disp_valid cycle; reg[rs1] cannot change in between.
                if (op == OP_DISPLAY) begin
                    disp_q <= regs[rs1];
                end
            end
        end
    end

    // Register file: cleared on reset, written at the edge leaving WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (state_q == S_WB && op != OP_DISPLAY) begin
            regs[rd] <= res_q;
        end
    end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: directed sequences followed by random
// instructions, checked against a register-file model held in the bench.
module tb_cpu_control_unit;

    logic        clk;
    logic        rst_n;
    logic        busy;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;
    logic [1:0]  dbg_state;

    cpu_control_unit_if bus ();

    cpu_control_unit #(.NREGS(16), .IMM_W(7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .busy      (busy),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Combinational ALU. CLEAR returns junk so the forced zero is visible.
    logic [15:0] alu_r;
    always_comb begin
        case (bus.alu_opcode)
            3'd0, 3'd1, 3'd2: alu_r = bus.alu_a + bus.alu_b;
            3'd3, 3'd4:       alu_r = bus.alu_a - bus.alu_b;
            3'd5:             alu_r = bus.alu_a * bus.alu_b;
            3'd6:             alu_r = 16'hDEAD;
            default:          alu_r = bus.alu_a;
        endcase
    end
    assign bus.alu_result = alu_r;

    // ---------------- scoreboard / model ----------------
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_q[$];
    logic [15:0] model_regs [16];
    logic [15:0] model_disp;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] ri(input logic [2:0] op, input int rd, input int rs1, input int imm);
        logic [3:0] d;
        logic [3:0] s;
        logic [6:0] i7;
        d  = rd[3:0];
        s  = rs1[3:0];
        i7 = imm[6:0];
        return {op, d, s, i7};
    endfunction

    function automatic logic [17:0] rr(input logic [2:0] op, input int rd, input int rs1, input int rs2);
        logic [3:0] d;
        logic [3:0] s;
        logic [3:0] t;
        d = rd[3:0];
        s = rs1[3:0];
        t = rs2[3:0];
        return {op, d, s, t, 3'b000};
    endfunction

    // Sweep the whole register file through the debug port (idle, valid low).
    task automatic check_all(input string tag);
        for (int i = 0; i < 16; i++) begin
            dbg_addr = i[3:0];
            #1;
            check(tag, dbg_data, model_regs[i]);
        end
        @(negedge clk);
    endtask

    // Driver: called at a negedge with the DUT idle. Presents one instruction,
    // checks EXEC and WB cycles, and returns at the following idle negedge.
    // With noise set, instr is scrambled while valid stays high during busy.
    task automatic run(input logic [17:0] ins, input bit noise);
        logic [2:0]  op;
        int          rd;
        int          rs1;
        int          rs2;
        longint      ra;
        longint      rb;
        longint      sx;
        longint      res;
        logic [15:0] ea;
        logic [15:0] eb;

        op  = ins[17:15];
        rd  = int'(ins[14:11]);
        rs1 = int'(ins[10:7]);
        rs2 = int'(ins[6:3]);
        ra  = longint'(model_regs[rs1]);
        rb  = longint'(model_regs[rs2]);
        sx  = (ins[6:0] >= 7'd64) ? longint'(ins[6:0]) - 128 : longint'(ins[6:0]);

        case (op)
            3'd0:    begin ea = 16'd0;              eb = sx[15:0];         res = sx;      end
            3'd1:    begin ea = model_regs[rs1];    eb = model_regs[rs2];  res = ra + rb; end
            3'd2:    begin ea = model_regs[rs1];    eb = sx[15:0];         res = ra + sx; end
            3'd3:    begin ea = model_regs[rs1];    eb = model_regs[rs2];  res = ra - rb; end
            3'd4:    begin ea = model_regs[rs1];    eb = sx[15:0];         res = ra - sx; end
            3'd5:    begin ea = model_regs[rs1];    eb = model_regs[rs2];  res = ra * rb; end
            3'd6:    begin ea = 16'd0;              eb = 16'd0;            res = 0;       end
            default: begin ea = model_regs[rs1];    eb = 16'd0;            res = 0;       end
        endcase

        bus.instr_valid = 1'b1;
        bus.instr       = ins;
        check("ready_idle", bus.instr_ready, 16'd1);
        check("busy_idle", busy, 16'd0);

        @(negedge clk);
        if (noise) bus.instr = 18'($urandom);
        check("ready_exec", bus.instr_ready, 16'd0);
        check("busy_exec", busy, 16'd1);
        check("done_exec", bus.done, 16'd0);
        check("disp_valid_exec", bus.disp_valid, 16'd0);
        check("alu_opcode_exec", bus.alu_opcode, op);
        check("alu_a_exec", bus.alu_a, ea);
        check("alu_b_exec", bus.alu_b, eb);

        @(negedge clk);
        if (noise) bus.instr = 18'($urandom);
        check("ready_wb", bus.instr_ready, 16'd0);
        check("busy_wb", busy, 16'd1);
        check("done_wb", bus.done, 16'd1);
        check("disp_valid_wb", bus.disp_valid, (op == 3'd7) ? 16'd1 : 16'd0);
        check("alu_opcode_wb", bus.alu_opcode, 16'd0);
        if (op == 3'd7) begin
            model_disp = model_regs[rs1];
            check("disp_data_wb", bus.disp_data, model_disp);
        end
        dbg_addr = rd[3:0];

        @(negedge clk);
        bus.instr_valid = 1'b0;
        if (op != 3'd7) model_regs[rd] = res[15:0];
        exp_q.push_back(model_regs[rd]);
        check("done_after", bus.done, 16'd0);
        check("disp_valid_after", bus.disp_valid, 16'd0);
        check("disp_data_hold", bus.disp_data, model_disp);
        check("busy_after", busy, 16'd0);
        check("ready_after", bus.instr_ready, 16'd1);
        check("reg_writeback", dbg_data, exp_q.pop_front());
    endtask

    // ---------------- directed and random stimulus ----------------
    initial begin
        rst_n           = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        dbg_addr        = '0;
        model_disp      = '0;
        for (int i = 0; i < 16; i++) model_regs[i] = '0;

        // Reset values.
        #1;
        check("rst_busy", busy, 16'd0);
        check("rst_done", bus.done, 16'd0);
        check("rst_disp_valid", bus.disp_valid, 16'd0);
        check("rst_disp_data", bus.disp_data, 16'd0);
        check("rst_alu_opcode", bus.alu_opcode, 16'd0);
        check("rst_alu_a", bus.alu_a, 16'd0);
        check("rst_alu_b", bus.alu_b, 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", bus.instr_ready, 16'd1);
        check_all("rst_regs");

        // LOAD / ADD, back to back with valid continuously high.
        run(ri(3'd0, 1, 0, 5), 1'b0);
        run(ri(3'd0, 2, 0, -3), 1'b0);
        run(rr(3'd1, 3, 1, 2), 1'b0);
        dbg_addr = 4'd3; #1;
        check("add_r3_is_2", dbg_data, 16'd2);
        @(negedge clk);

        // CLEAR (ALU answers junk) and DISPLAY of r1=5.
        run(ri(3'd6, 3, 1, 0), 1'b0);
        run(ri(3'd7, 9, 1, 0), 1'b0);
        check("display_value", bus.disp_data, 16'd5);
        check_all("after_display");

        // Immediates and wrap-around.
        run(ri(3'd0, 4, 0, 63), 1'b0);
        run(ri(3'd2, 4, 4, -64), 1'b0);
        check("addi_neg", dbg_data, 16'hFFFF);
        run(ri(3'd0, 5, 0, 0), 1'b0);
        for (int i = 0; i < 520; i++) run(ri(3'd2, 5, 5, 63), 1'b0);
        run(ri(3'd2, 5, 5, 7), 1'b0);
        check("r5_max", dbg_data, 16'h7FFF);
        run(ri(3'd2, 5, 5, 1), 1'b0);
        check("r5_wrap", dbg_data, 16'h8000);
        run(ri(3'd4, 6, 0, 1), 1'b0);
        check("subi_zero", dbg_data, 16'hFFFF);

        // MUL truncation: 300 * 300.
        run(ri(3'd0, 1, 0, 0), 1'b0);
        run(ri(3'd0, 2, 0, 0), 1'b0);
        for (int i = 0; i < 4; i++) begin
            run(ri(3'd2, 1, 1, 63), 1'b0);
            run(ri(3'd2, 2, 2, 63), 1'b0);
        end
        run(ri(3'd2, 1, 1, 48), 1'b0);
        run(ri(3'd2, 2, 2, 48), 1'b0);
        run(rr(3'd5, 7, 1, 2), 1'b0);
        check("mul_trunc", dbg_data, 16'd24464);

        // Busy handshake: instr scrambled with valid high during EXEC/WB.
        run(rr(3'd3, 8, 7, 1), 1'b1);
        run(rr(3'd1, 8, 8, 8), 1'b1);
        check_all("after_noise");

        // Reset in the middle of an ADD's EXEC cycle.
        bus.instr_valid = 1'b1;
        bus.instr       = rr(3'd1, 3, 1, 2);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 16'd0);
        check("midrst_done", bus.done, 16'd0);
        check("midrst_disp_valid", bus.disp_valid, 16'd0);
        check("midrst_alu_opcode", bus.alu_opcode, 16'd0);
        check("midrst_alu_a", bus.alu_a, 16'd0);
        @(negedge clk);
        check("midrst_done_held", bus.done, 16'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_ready", bus.instr_ready, 16'd1);
        check("midrst_no_done", bus.done, 16'd0);
        check("midrst_disp_data", bus.disp_data, 16'd0);
        for (int i = 0; i < 16; i++) model_regs[i] = '0;
        model_disp = '0;
        check_all("midrst_regs");

        // Random instructions, random busy-time noise.
        for (int n = 0; n < 200; n++) begin
            run(18'($urandom), 1'($urandom_range(0, 1)));
        end
        check_all("final_regs");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_control_unit.md
# cpu_control_unit

Multi-cycle sequencer for the 16-bit CPU datapath. It accepts one 18-bit instruction at a time over a valid/ready handshake and decodes it. It reads operands from an internal 16×16 register file, drives the combinational ALU (opcode, A, B), writes the ALU result back, and emits DISPLAY values to the board output. It sits between the instruction source (switch panel or program ROM) and the ALU instance.

## Interface
- `NREGS`, default 16: register-file depth; fixed at 16, which sets the 4-bit register fields.
- `IMM_W`, default 7: immediate field width. The immediate is sign-extended to 16 bits.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: reset, **asynchronous, active-low**.
- `instr_valid` input, 1 bit: the source presents an instruction.
- `instr` input, 18 bits, with these fields:
  - [17:15] opcode
  - [14:11] rd
  - [10:7] rs1
  - [6:0] imm7, or [6:3] rs2
- `instr_ready` output, 1 bit: high only in IDLE.
- `alu_opcode` output, 3 bits: opcode presented to the ALU.
- `alu_a` output, 16 bits, signed: ALU operand A.
- `alu_b` output, 16 bits, signed: ALU operand B.
- `alu_result` input, 16 bits, signed: combinational ALU result.
- `done` output, 1 bit: one-cycle pulse when an instruction retires.
- `disp_valid` output, 1 bit: one-cycle pulse carrying a DISPLAY value.
- `disp_data` output, 16 bits: value being displayed; holds its last value between pulses.
- `busy` output, 1 bit: high when the state is not IDLE.
- `dbg_addr` input, 4 bits: debug read address.
- `dbg_data` output, 16 bits: combinational read of `reg[dbg_addr]`.

## Operation
- **Opcodes:**
  - 000 LOAD
  - 001 ADD
  - 010 ADDI
  - 011 SUB
  - 100 SUBI
  - 101 MUL
  - 110 CLEAR
  - 111 DISPLAY
- **FSM states:** IDLE → EXEC → WB → IDLE. There are no other states.
- **IDLE:**
  - `instr_ready=1`.
  - On `instr_valid && instr_ready` at a rising edge, latch `instr` and go to EXEC.
  - Otherwise stay in IDLE.
- **EXEC:**
  - `alu_opcode` = latched opcode.
  - Operands by opcode:
    - LOAD: A=0, B=sext(imm7).
    - ADDI/SUBI: A=`reg[rs1]`, B=sext(imm7).
    - ADD/SUB/MUL: A=`reg[rs1]`, B=`reg[rs2]`.
    - CLEAR: A=0, B=0.
    - DISPLAY: A=`reg[rs1]`, B=0.
  - At the edge leaving EXEC, register `alu_result` into `res_q` and go to WB.
- **WB:**
  - For opcodes 000–110, write `reg[rd] <= res_q`. CLEAR therefore writes 0, regardless of the ALU's answer.
  - For DISPLAY, there is no register write; `disp_data <= reg[rs1]` and `disp_valid` pulses.
  - `done` pulses in WB for every opcode.
  - Next state is IDLE.
- **ALU outputs outside EXEC:** `alu_opcode=3'b000`, `alu_a=0`, `alu_b=0`.
- **Arithmetic:** 16-bit two's complement with wrap-around, no saturation and no flags. MUL keeps the low 16 bits.
- **Registers:** all 16 are general-purpose and writable; there is no hardwired zero. `rd` may equal `rs1` or `rs2`. Operands are read in EXEC and the write happens in WB, so there is no hazard.
- **Handshake:**
  - `instr_valid` while busy is ignored. The source must hold `instr` stable until accepted.
  - `instr` changes after acceptance have no effect.
  - `instr_valid` may be held high continuously; each IDLE cycle accepts one instruction.

## Timing
- **Reset (`rst_n=0`, asynchronous):**
  - State=IDLE; all 16 registers=0.
  - `done`, `disp_valid`, `busy` = 0; `disp_data`=0; ALU outputs = 0.
  - `instr_ready` is 1 after reset. Instructions are not accepted while `rst_n=0`.
- **Reset mid-instruction** (in EXEC or WB): the instruction is discarded, with no register write, no `done` and no `disp_valid`. The FSM resumes in IDLE on the first edge after release.
- **Latency:** acceptance at edge N, EXEC during cycle N+1, WB during cycle N+2. `done`/`disp_valid` are high in cycle N+2 and the register write lands at edge N+3.
- **Throughput:** one instruction per 3 cycles. The next acceptance is at edge N+3 at the earliest.
- **`dbg_data`:** reflects a write from the cycle after the WB edge.

## Test plan
- **Reset:** assert `rst_n=0` mid-EXEC of an ADD. All registers read 0 via `dbg`, with no `done` pulse, and `instr_ready=1` after release.
- **LOAD/ADD:**
  - Sequence: LOAD r1,5; LOAD r2,-3; ADD r3,r1,r2.
  - Expected: `dbg` r3 = 16'd2; `done` pulses at accept+2 for each instruction; accepts spaced 3 cycles apart with `instr_valid` held high.
- **Immediates and wrap:**
  - Sequence: LOAD r4,63; ADDI r4,r4,-64 gives r4=−1 (16'hFFFF).
  - Then: r5=16'h7FFF built by repeated ADDI, then ADDI r5,r5,1 gives 16'h8000 (wrap).
  - Then: SUBI r6,r0,1 gives 16'hFFFF.
- **MUL truncation:** r1=300, r2=300 via ADDI chains, then MUL r7,r1,r2. Expected r7 = 90000 mod 65536 = 16'd24464.
- **CLEAR/DISPLAY:**
  - CLEAR r3 gives r3=0.
  - DISPLAY rs1=r1 (r1=5): `disp_valid` is 1 for exactly one cycle with `disp_data`=5, no register changes, and `alu_opcode`=3'b111 during EXEC.
- **Busy handshake:**
  - Toggle `instr` and hold `instr_valid` during EXEC/WB. `instr_ready`=0 and the changes are ignored.
  - The latched instruction's result alone appears.
  - `busy` is high for exactly 2 cycles per instruction.
